// File: rtl/mem_copy.sv
// Block-copy engine that drives a register-bank memory.
// Each word is copied as one read cycle followed by one write cycle, in ascending address order.
module mem_copy #(
    parameter int unsigned M = 8,
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] src,
    input  logic [N-1:0] dst,
    input  logic [N:0]   len,
    output logic         busy,
    output logic         done,
    output logic [N:0]   count,
    output logic [N-1:0] mem_addr,
    output logic [M-1:0] mem_din,
    output logic         mem_wrt,
    input  logic [M-1:0] mem_dout
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    localparam logic [N:0] One = {{N{1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [N-1:0] src_q, src_d;
    logic [N-1:0] dst_q, dst_d;
    logic [N:0]   len_q, len_d;
    logic [N:0]   count_q, count_d;
    logic [M-1:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        count_d = count_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    src_d   = src;
                    dst_d   = dst;
                    len_d   = len;
                    count_d = '0;
                    state_d = (len == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                data_d  = mem_dout;
                state_d = StWrite;
            end
            StWrite: begin
                count_d = count_q + One;
                state_d = (count_q + One == len_q) ? StDone : StRead;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        mem_wrt  = 1'b0;
        mem_addr = '0;
        unique case (state_q)
            StRead: begin
                busy     = 1'b1;
                mem_addr = src_q + count_q[N-1:0];
            end
            StWrite: begin
                busy     = 1'b1;
                mem_addr = dst_q + count_q[N-1:0];
                // A write still pending when reset arrives must not land in memory.
                mem_wrt  = ~reset;
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

    // data_q only changes at the end of a read, so it keeps the last written word.
    assign mem_din = data_q;
    assign count   = count_q;

endmodule

// File: tb/tb_mem_copy.sv
// Directed bench for mem_copy: the bench owns the memory model and checks
// copy results, cycle timing and the reset, wrap and overlap corner cases.
module tb_mem_copy;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] src, dst;
    logic [4:0] len;
    logic       busy, done, mem_wrt;
    logic [4:0] count;
    logic [3:0] mem_addr;
    logic [7:0] mem_din, mem_dout;

    logic [7:0] mem [16];
    logic       pl_en;
    logic [3:0] pl_addr;
    logic [7:0] pl_data;
    logic [3:0] rd_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    mem_copy #(.M(8), .N(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_wrt  (mem_wrt),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wrt) mem[mem_addr] <= mem_din;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_done"}, int'(done), 0);
        check_eq({tag, "_count"}, int'(count), 0);
        check_eq({tag, "_wrt"}, int'(mem_wrt), 0);
        check_eq({tag, "_addr"}, int'(mem_addr), 0);
        check_eq({tag, "_din"}, int'(mem_din), 0);
    endtask

    // Cycle n is the n-th cycle after the edge that accepts start.
    task automatic run_copy(input logic [3:0] s, input logic [3:0] d, input logic [4:0] l,
                            output int done_at, output int busy_n, output int wrt_n,
                            output int pulses);
        done_at = -1; busy_n = 0; wrt_n = 0; pulses = 0;
        rd_q.delete();
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = l;
        for (int n = 1; n <= 2 * int'(l) + 4; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (done) begin
                pulses++;
                if (done_at < 0) done_at = n;
            end
            if (busy) busy_n++;
            if (mem_wrt) wrt_n++;
            if (busy && !mem_wrt) rd_q.push_back(mem_addr);
        end
    endtask

    int done_at, busy_n, wrt_n, pulses;

    initial begin
        reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // Basic four-word copy
        poke(2, 11); poke(3, 22); poke(4, 33); poke(5, 44);
        run_copy(2, 10, 4, done_at, busy_n, wrt_n, pulses);
        check_eq("basic_done_at", done_at, 9);
        check_eq("basic_busy", busy_n, 8);
        check_eq("basic_pulses", pulses, 1);
        check_eq("basic_count", int'(count), 4);
        check_eq("basic_m10", int'(mem[10]), 11);
        check_eq("basic_m11", int'(mem[11]), 22);
        check_eq("basic_m12", int'(mem[12]), 33);
        check_eq("basic_m13", int'(mem[13]), 44);
        check_eq("basic_src2", int'(mem[2]), 11);
        check_eq("basic_src5", int'(mem[5]), 44);
        check_eq("basic_din_hold", int'(mem_din), 44);

        // Zero-length copy
        poke(7, 55);
        run_copy(3, 7, 0, done_at, busy_n, wrt_n, pulses);
        check_eq("len0_done_at", done_at, 1);
        check_eq("len0_wrt", wrt_n, 0);
        check_eq("len0_busy", busy_n, 0);
        check_eq("len0_count", int'(count), 0);
        check_eq("len0_m7", int'(mem[7]), 55);

        // Address wrap on the source side
        poke(14, 1); poke(15, 2); poke(0, 3); poke(1, 4);
        run_copy(14, 4, 4, done_at, busy_n, wrt_n, pulses);
        check_eq("wrap_nrd", rd_q.size(), 4);
        if (rd_q.size() == 4) begin
            check_eq("wrap_rd0", int'(rd_q[0]), 14);
            check_eq("wrap_rd1", int'(rd_q[1]), 15);
            check_eq("wrap_rd2", int'(rd_q[2]), 0);
            check_eq("wrap_rd3", int'(rd_q[3]), 1);
        end
        check_eq("wrap_m4", int'(mem[4]), 1);
        check_eq("wrap_m5", int'(mem[5]), 2);
        check_eq("wrap_m6", int'(mem[6]), 3);
        check_eq("wrap_m7", int'(mem[7]), 4);

        // Overlapping regions with dst > src propagate the first word
        poke(0, 127); poke(1, 5); poke(2, 6);
        run_copy(0, 1, 3, done_at, busy_n, wrt_n, pulses);
        check_eq("ovl_m1", int'(mem[1]), 127);
        check_eq("ovl_m2", int'(mem[2]), 127);
        check_eq("ovl_m3", int'(mem[3]), 127);

        // start held through the busy and done cycles must be ignored
        poke(8, 8'hA1); poke(9, 8'hA2);
        done_at = -1; busy_n = 0; pulses = 0;
        @(negedge clk);
        start = 1'b1; src = 8; dst = 14; len = 2;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (done_at < 0) done_at = n;
            end
            if (busy) busy_n++;
            start = (n >= 1 && n <= 4);
            src = 4; dst = 0;
        end
        start = 1'b0;
        check_eq("ign_done_at", done_at, 5);
        check_eq("ign_pulses", pulses, 1);
        check_eq("ign_busy", busy_n, 4);
        check_eq("ign_m14", int'(mem[14]), 8'hA1);
        check_eq("ign_m15", int'(mem[15]), 8'hA2);
        check_eq("ign_m0", int'(mem[0]), 127);

        // Reset during the third write
        poke(0, 9); poke(1, 8); poke(2, 7); poke(3, 6); poke(10, 8'h5A);
        @(negedge clk);
        start = 1'b1; src = 0; dst = 8; len = 4;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check_eq("mid_wrt_before", int'(mem_wrt), 1);
        reset = 1'b1;
        #1;
        check_eq("mid_wrt_forced", int'(mem_wrt), 0);
        @(negedge clk);
        check_reset_outputs("mid");
        reset = 1'b0;
        check_eq("mid_m8", int'(mem[8]), 9);
        check_eq("mid_m9", int'(mem[9]), 8);
        check_eq("mid_m10", int'(mem[10]), 8'h5A);
        run_copy(0, 8, 4, done_at, busy_n, wrt_n, pulses);
        check_eq("again_done_at", done_at, 9);
        check_eq("again_m10", int'(mem[10]), 7);
        check_eq("again_m11", int'(mem[11]), 6);

        // Full-memory length
        run_copy(0, 0, 16, done_at, busy_n, wrt_n, pulses);
        check_eq("full_done_at", done_at, 33);
        check_eq("full_wrt", wrt_n, 16);
        check_eq("full_count", int'(count), 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_copy.md
Name: mem_copy

Overview:
- Initiator-side engine that drives the register-bank memory `mem` port set: address, write data, write enable, read data.
- On a start command it copies a block of LEN words from a source address to a destination address inside the same memory, one word at a time, as a read then a write.
- Sits between a control FSM/testbench and `mem`, taking ownership of `mem`'s addr/Min/wrt lines while busy.

Parameters:
M, 8, memory word width in bits (matches `mem` M)
N, 4, memory address width; memory depth 2^N words (matches `mem` N)

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous active-high reset
start  input  1  command strobe, sampled only in IDLE
src  input  N  source start address, captured on accepted start
dst  input  N  destination start address, captured on accepted start
len  input  N+1  word count 0..2^N, captured on accepted start
busy  output  1  high while a copy is in progress (READ/WRITE states)
done  output  1  one-cycle pulse when a copy completes, including len=0
count  output  N+1  words written so far in current/last copy
mem_addr  output  N  drives `mem` addr
mem_din  output  M  drives `mem` Min
mem_wrt  output  1  drives `mem` wrt
mem_dout  input  M  from `mem` Mout

Behaviour:
- Memory contract: read is asynchronous (mem_dout = mem[mem_addr] in the same cycle); write occurs at the rising clk edge when mem_wrt=1.
- Reset, synchronous and active-high, sets: state=IDLE, busy=0, done=0, count=0, mem_wrt=0, mem_addr=0, mem_din=0, and the internal src/dst/len/data registers to 0.
- Outputs are registered or decoded from state only. No combinational path from start to mem_wrt.

States:
- IDLE:
  - busy=0, mem_wrt=0.
  - If start=1: capture src, dst and len; clear count to 0.
  - len=0 goes to DONE; otherwise goes to READ.
- READ:
  - mem_addr=src_r+count (mod 2^N), mem_wrt=0.
  - At the edge, latch mem_dout into data_r and go to WRITE.
- WRITE:
  - mem_addr=dst_r+count (mod 2^N), mem_din=data_r, mem_wrt=1.
  - At the edge, count increments.
  - If count+1 == len_r, go to DONE; otherwise go to READ.
- DONE:
  - done=1 for exactly this cycle, busy=0, mem_wrt=0.
  - Always returns to IDLE.

Timing:
- Accepted start at edge k gives READ in cycle k+1.
- Each word takes 2 cycles.
- done is high in cycle k+2L+1 for len=L.
- For len=0, done is high in cycle k+1.

Boundary conditions:
- Address arithmetic wraps modulo 2^N for both src and dst sequences.
- len=2^N copies the entire memory.
- Copy order is strictly ascending and each word is read just before its write. Overlapping regions with dst>src therefore propagate: every destination word receives the value currently in memory at read time. This is the defined behaviour.
- start while busy or in DONE is ignored and not queued.
- reset asserted mid-copy: next cycle is IDLE with mem_wrt=0. A write in progress during the reset cycle is suppressed (mem_wrt is forced 0 combinationally when reset=1). Partial copy results remain in memory.
- count holds its final value after DONE until the next accepted start or reset.
- mem_din holds the last written value when not in WRITE. mem_addr is 0 in IDLE.

Test Plan:
- Preload mem[2..5]=11,22,33,44; start with src=2, dst=10, len=4 -> mem[10..13]=11,22,33,44. done pulses 9 cycles after the start edge. count=4. busy is high for 8 cycles. src words are unchanged.
- start with len=0 (src=3, dst=7) -> done pulses on the next cycle. mem_wrt never goes high. count=0. mem[7] is unchanged.
- Wrap: preload mem[14]=1, mem[15]=2, mem[0]=3, mem[1]=4; start with src=14, dst=4, len=4 -> mem[4..7]=1,2,3,4. The mem_addr read sequence is 14,15,0,1.
- Overlap: mem[0]=127, mem[1]=5, mem[2]=6; start with src=0, dst=1, len=3 -> mem[1..3] all =127.
- start pulsed again while busy with different src/dst -> ignored. The first copy completes unchanged with a single done pulse.
- Reset mid-copy: start with src=0, dst=8, len=4 (mem[0..3]=9,8,7,6); assert reset during the third WRITE cycle -> mem[8]=9, mem[9]=8, mem[10] is unchanged. All outputs are at reset values the next cycle. A subsequent full copy succeeds.
